// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache between fetch and the
// memory IO controller. Each of the 2^IDX_W entries holds one instruction
// (a 32-bit word, or a 16-bit compressed form that arrives zero-extended).
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   en                  global ready; when low, all state holds and no pulses are generated
//   if_en_i, if_pc_i    fetch request strobe and halfword-aligned PC
//   if_en_o, if_ins_o,  response pulse, instruction and its PC
//   if_pc_o
//   mc_en_o, mc_pc_o    miss read request pulse and miss address (held during WAIT)
//   mc_en_i, mc_ins_i   memory controller done pulse and returned instruction
//   br_flag             branch flush: abort any outstanding miss, keep contents
module icache_direct #(
    parameter int IDX_W = 6,
    parameter int DAT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             if_en_i,
    input  logic [DAT_W-1:0] if_pc_i,
    output logic             if_en_o,
    output logic [DAT_W-1:0] if_ins_o,
    output logic [DAT_W-1:0] if_pc_o,
    output logic             mc_en_o,
    output logic [DAT_W-1:0] mc_pc_o,
    input  logic             mc_en_i,
    input  logic [DAT_W-1:0] mc_ins_i,
    input  logic             br_flag
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = DAT_W - IDX_W - 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nxt;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [DAT_W-1:0]   data_mem [ENTRIES];

    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic             hit;
    logic             do_hit, do_miss, do_fill;

    // mc_pc_o doubles as the latched miss PC: it is loaded on the miss and
    // held untouched until the next miss, so the fill uses it directly.
    assign req_idx  = if_pc_i[IDX_W:1];
    assign req_tag  = if_pc_i[DAT_W-1:IDX_W+1];
    assign miss_idx = mc_pc_o[IDX_W:1];
    assign miss_tag = mc_pc_o[DAT_W-1:IDX_W+1];
    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    // Flush wins over everything: it drops a same-cycle request and any
    // same-cycle completion. A completion seen in IDLE (e.g. a late one
    // after a flush) falls through and writes nothing.
    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_fill   = 1'b0;
        if (br_flag) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (if_en_i) begin
                        if (hit) begin
                            do_hit = 1'b1;
                        end else begin
                            do_miss   = 1'b1;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mc_en_i) begin
                        do_fill   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (en && do_fill)
            valid[miss_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (en && do_fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mc_ins_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_en_o  <= 1'b0;
            if_ins_o <= '0;
            if_pc_o  <= '0;
            mc_en_o  <= 1'b0;
            mc_pc_o  <= '0;
        end else if (!en) begin
            if_en_o <= 1'b0;
            mc_en_o <= 1'b0;
        end else begin
            if_en_o <= do_hit | do_fill;
            mc_en_o <= do_miss;
            if (do_hit) begin
                if_ins_o <= data_mem[req_idx];
                if_pc_o  <= if_pc_i;
            end
            if (do_fill) begin
                if_ins_o <= mc_ins_i;
                if_pc_o  <= mc_pc_o;
            end
            if (do_miss)
                mc_pc_o <= if_pc_i;
        end
    end
endmodule
